pwm_cmp_sched: RTL and testbench

- Register-mapped scheduler between the I2C slave register port and the two PWM cores (pwm0, pwm1).
- Stages byte-wise writes of each channel's 18-bit compare value (14-bit integer, 3-bit dither, 1-bit LSB) in shadow registers.
- On a commit request, transfers the staged value to the active compare exactly at that channel's next PWM period boundary, so no glitched period is produced.
- Drives the alert line on completion.

---
 rtl/pwm_cmp_sched.sv | 184 ++++++++++++++++++
 tb/tb_pwm_cmp_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cmp_sched.sv
// Compare-value scheduler between the I2C register port and the two PWM cores.
// Optional macro PWM_UPD_TIMEOUT_EN adds a per-channel watchdog that forces a stalled update.
module pwm_cmp_sched #(
    parameter int               CMP_W   = 18,
    parameter logic [CMP_W-1:0] CMP_MAX = 18'h3FFFF,
    parameter int               TMO_CYC = 65535
) (
    input  logic             clk_USB,
    input  logic             rstn,
    input  logic             reg_wr,
    input  logic             reg_rd,
    input  logic [7:0]       reg_addr,
    input  logic [7:0]       reg_wdata,
    output logic [7:0]       reg_rdata,
    input  logic [1:0]       per_end,
    output logic [CMP_W-1:0] cmp0,
    output logic [CMP_W-1:0] cmp1,
    output logic [1:0]       upd_done,
    output logic             alert_n
);

    typedef enum logic [1:0] {IDLE, PEND, LOAD} state_t;

    state_t           state     [2];
    state_t           state_nxt [2];
    logic [CMP_W-1:0] stage     [2];
    logic [CMP_W-1:0] active    [2];
    logic [CMP_W:0]   headroom  [2];
    logic [2:0]       byte_wr   [2];

    logic [1:0] pending;
    logic [1:0] busy;
    logic [1:0] commit_wr;
    logic [1:0] load_go;
    logic [1:0] over_max;
    logic [1:0] clamp_set;
    logic [1:0] reject_set;
    logic [1:0] tmo_hit;
    logic [1:0] done_st;
    logic [1:0] clamp_st;
    logic       reject_st;
    logic       tmo_st;
    logic       status_clr;
    logic [7:0] rd_mux;

    // Register decode; a borrow out of CMP_MAX - staged flags a value above the clamp.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            commit_wr[n] = reg_wr && (reg_addr == 8'h03) && reg_wdata[n];
            for (int b = 0; b < 3; b++) begin
                byte_wr[n][b] = reg_wr && (reg_addr == 8'(4 * n + b));
            end
            reject_set[n] = (|byte_wr[n]) && busy[n];
            load_go[n]    = (state[n] == PEND) && (per_end[n] || tmo_hit[n]);
            headroom[n]   = {1'b0, CMP_MAX} - {1'b0, stage[n]};
            over_max[n]   = headroom[n][CMP_W];
            clamp_set[n]  = load_go[n] && over_max[n];
        end
        status_clr = reg_rd && (reg_addr == 8'h07);
    end

`ifdef PWM_UPD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt [2];

    always_ff @(posedge clk_USB or negedge rstn) begin
        if (!rstn) begin
            for (int n = 0; n < 2; n++) tmo_cnt[n] <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                tmo_cnt[n] <= ((state[n] == PEND) && !load_go[n]) ? tmo_cnt[n] + 1'b1 : '0;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            tmo_hit[n] = (state[n] == PEND) && !per_end[n]
                         && (tmo_cnt[n] == TMO_W'(TMO_CYC - 1));
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_CYC != 0);
    assign tmo_hit    = 2'b00;
`endif

    always_ff @(posedge clk_USB or negedge rstn) begin
        if (!rstn) begin
            for (int n = 0; n < 2; n++) state[n] <= IDLE;
        end else begin
            for (int n = 0; n < 2; n++) state[n] <= state_nxt[n];
        end
    end

    // A per_end arriving with the commit write is seen while still IDLE, so it is skipped.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_nxt[n] = state[n];
            case (state[n])
                IDLE:    if (commit_wr[n]) state_nxt[n] = PEND;
                PEND:    if (load_go[n])   state_nxt[n] = LOAD;
                LOAD:    state_nxt[n] = IDLE;
                default: state_nxt[n] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            pending[n]  = (state[n] == PEND);
            busy[n]     = (state[n] != IDLE);
            upd_done[n] = (state[n] == LOAD);
        end
    end

    always_ff @(posedge clk_USB or negedge rstn) begin
        if (!rstn) begin
            for (int n = 0; n < 2; n++) stage[n] <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (!busy[n]) begin
                    if (byte_wr[n][0]) stage[n][7:0]   <= reg_wdata;
                    if (byte_wr[n][1]) stage[n][15:8]  <= reg_wdata;
                    if (byte_wr[n][2]) stage[n][17:16] <= reg_wdata[1:0];
                end
            end
        end
    end

    // Active compare is written on the per_end edge so it is visible in the LOAD cycle.
    always_ff @(posedge clk_USB or negedge rstn) begin
        if (!rstn) begin
            for (int n = 0; n < 2; n++) active[n] <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (load_go[n]) active[n] <= over_max[n] ? CMP_MAX : stage[n];
            end
        end
    end

    // Sticky set events take priority over a status-read clear in the same cycle.
    always_ff @(posedge clk_USB or negedge rstn) begin
        if (!rstn) begin
            done_st   <= 2'b00;
            clamp_st  <= 2'b00;
            reject_st <= 1'b0;
            tmo_st    <= 1'b0;
        end else begin
            done_st   <= (status_clr ? 2'b00 : done_st) | load_go;
            clamp_st  <= (status_clr ? 2'b00 : clamp_st) | clamp_set;
            reject_st <= (!status_clr && reject_st) || (|reject_set);
            tmo_st    <= (!status_clr && tmo_st) || (|tmo_hit);
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (reg_addr)
            8'h00:   rd_mux = stage[0][7:0];
            8'h01:   rd_mux = stage[0][15:8];
            8'h02:   rd_mux = {6'b0, stage[0][17:16]};
            8'h04:   rd_mux = stage[1][7:0];
            8'h05:   rd_mux = stage[1][15:8];
            8'h06:   rd_mux = {6'b0, stage[1][17:16]};
            8'h07:   rd_mux = {tmo_st, reject_st, clamp_st, done_st, pending};
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk_USB or negedge rstn) begin
        if (!rstn) begin
            reg_rdata <= 8'h00;
        end else if (reg_rd) begin
            reg_rdata <= rd_mux;
        end
    end

    assign cmp0    = active[0];
    assign cmp1    = active[1];
    assign alert_n = ~((|done_st) | (|clamp_st) | reject_st | tmo_st);

endmodule

// File: tb/tb_pwm_cmp_sched.sv
// Self-checking bench for pwm_cmp_sched: directed scenarios plus randomized traffic
// compared against a transaction-level model (honours PWM_UPD_TIMEOUT_EN when defined).
module tb_pwm_cmp_sched;

    localparam int          CMP_W   = 18;
    localparam logic [17:0] CMP_MAX = 18'h10000;
    localparam int          TMO_CYC = 100;
`ifdef PWM_UPD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk_USB   = 1'b0;
    logic              rstn      = 1'b0;
    logic              reg_wr    = 1'b0;
    logic              reg_rd    = 1'b0;
    logic [7:0]        reg_addr  = 8'h00;
    logic [7:0]        reg_wdata = 8'h00;
    logic [1:0]        per_end   = 2'b00;
    logic [7:0]        reg_rdata;
    logic [CMP_W-1:0]  cmp0;
    logic [CMP_W-1:0]  cmp1;
    logic [1:0]        upd_done;
    logic              alert_n;

    int total = 0;
    int bad   = 0;

    logic [17:0] m_stage  [2];
    logic [17:0] m_active [2];
    bit          m_pend   [2];
    bit          m_load   [2];
    int          m_age    [2];
    logic [1:0]  m_done;
    logic [1:0]  m_clamp;
    bit          m_reject;
    bit          m_tmo;
    logic [7:0]  m_rdata;

    pwm_cmp_sched #(.CMP_W(CMP_W), .CMP_MAX(CMP_MAX), .TMO_CYC(TMO_CYC)) dut (
        .clk_USB  (clk_USB),
        .rstn     (rstn),
        .reg_wr   (reg_wr),
        .reg_rd   (reg_rd),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .per_end  (per_end),
        .cmp0     (cmp0),
        .cmp1     (cmp1),
        .upd_done (upd_done),
        .alert_n  (alert_n)
    );

    always #5 clk_USB = ~clk_USB;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_stage[n] = '0; m_active[n] = '0; m_pend[n] = 0; m_load[n] = 0; m_age[n] = 0;
        end
        m_done = 2'b00; m_clamp = 2'b00; m_reject = 0; m_tmo = 0; m_rdata = 8'h00;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return m_stage[0][7:0];
            8'h01:   return m_stage[0][15:8];
            8'h02:   return {6'b0, m_stage[0][17:16]};
            8'h04:   return m_stage[1][7:0];
            8'h05:   return m_stage[1][15:8];
            8'h06:   return {6'b0, m_stage[1][17:16]};
            8'h07:   return {m_tmo, m_reject, m_clamp, m_done, m_pend[1], m_pend[0]};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic m_alert_n();
        return !((|m_done) || (|m_clamp) || m_reject || m_tmo);
    endfunction

    // One register-port cycle of the reference model: everything decided from pre-cycle values.
    task automatic model_cycle(input bit wr, input bit rd, input logic [7:0] a,
                               input logic [7:0] d, input logic [1:0] pe);
        logic [17:0] n_stage [2];
        logic [17:0] n_active [2];
        bit          n_pend [2];
        bit          n_load [2];
        int          n_age [2];
        logic [1:0]  n_done;
        logic [1:0]  n_clamp;
        bit          n_rej;
        bit          n_tmo;
        int          off;
        if (rd) m_rdata = m_read(a);
        n_done  = (rd && a == 8'h07) ? 2'b00 : m_done;
        n_clamp = (rd && a == 8'h07) ? 2'b00 : m_clamp;
        n_rej   = (rd && a == 8'h07) ? 1'b0 : m_reject;
        n_tmo   = (rd && a == 8'h07) ? 1'b0 : m_tmo;
        for (int n = 0; n < 2; n++) begin
            n_stage[n] = m_stage[n]; n_active[n] = m_active[n];
            n_pend[n] = m_pend[n]; n_load[n] = 0; n_age[n] = m_age[n];
            if (m_pend[n]) begin
                if (pe[n] || (TMO_EN && m_age[n] == TMO_CYC - 1)) begin
                    n_active[n] = (m_stage[n] > CMP_MAX) ? CMP_MAX : m_stage[n];
                    if (m_stage[n] > CMP_MAX) n_clamp[n] = 1'b1;
                    if (!pe[n]) n_tmo = 1'b1;
                    n_done[n] = 1'b1; n_pend[n] = 0; n_load[n] = 1;
                end else begin
                    n_age[n] = m_age[n] + 1;
                end
            end else if (!m_load[n] && wr && a == 8'h03 && d[n]) begin
                n_pend[n] = 1; n_age[n] = 0;
            end
            off = int'(a) - 4 * n;
            if (wr && off >= 0 && off <= 2) begin
                if (m_pend[n] || m_load[n]) n_rej = 1'b1;
                else if (off == 0) n_stage[n][7:0] = d;
                else if (off == 1) n_stage[n][15:8] = d;
                else n_stage[n][17:16] = d[1:0];
            end
        end
        for (int n = 0; n < 2; n++) begin
            m_stage[n] = n_stage[n]; m_active[n] = n_active[n];
            m_pend[n] = n_pend[n]; m_load[n] = n_load[n]; m_age[n] = n_age[n];
        end
        m_done = n_done; m_clamp = n_clamp; m_reject = n_rej; m_tmo = n_tmo;
    endtask

    task automatic step(input bit wr, input bit rd, input logic [7:0] a,
                        input logic [7:0] d, input logic [1:0] pe);
        reg_wr = wr; reg_rd = rd; reg_addr = a; reg_wdata = d; per_end = pe;
        model_cycle(wr, rd, a, d, pe);
        @(posedge clk_USB); #1;
        reg_wr = 1'b0; reg_rd = 1'b0; per_end = 2'b00;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        step(1'b1, 1'b0, a, d, 2'b00);
    endtask

    task automatic rd_reg(input logic [7:0] a);
        step(1'b0, 1'b1, a, 8'h00, 2'b00);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    endtask

    task automatic test_reset();
        rstn = 1'b0; model_reset();
        #12;
        total++; if (cmp0 !== 18'h0) begin bad++; $display("[TB] FAIL reset_cmp0 got=%h exp=%h", cmp0, 18'h0); end
        total++; if (cmp1 !== 18'h0) begin bad++; $display("[TB] FAIL reset_cmp1 got=%h exp=%h", cmp1, 18'h0); end
        total++; if (upd_done !== 2'b00) begin bad++; $display("[TB] FAIL reset_upd_done got=%b exp=00", upd_done); end
        total++; if (alert_n !== 1'b1) begin bad++; $display("[TB] FAIL reset_alert_n got=%b exp=1", alert_n); end
        total++; if (reg_rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata got=%h exp=00", reg_rdata); end
        rstn = 1'b1;
        @(posedge clk_USB); #1;
        rd_reg(8'h07);
        total++; if (reg_rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_status got=%h exp=00", reg_rdata); end
    endtask

    task automatic test_basic();
        wr_reg(8'h00, 8'h68); wr_reg(8'h01, 8'h02); wr_reg(8'h02, 8'h00); wr_reg(8'h03, 8'h01);
        idle(2);
        total++; if (cmp0 !== 18'h0) begin bad++; $display("[TB] FAIL basic_cmp0_hold got=%h exp=%h", cmp0, 18'h0); end
        step(1'b0, 1'b0, 8'h00, 8'h00, 2'b01);
        total++; if (cmp0 !== 18'h00268 || cmp0 !== m_active[0]) begin bad++; $display("[TB] FAIL basic_cmp0 got=%h exp=%h", cmp0, 18'h00268); end
        total++; if (upd_done !== 2'b01) begin bad++; $display("[TB] FAIL basic_upd_done got=%b exp=01", upd_done); end
        total++; if (alert_n !== 1'b0) begin bad++; $display("[TB] FAIL basic_alert_n got=%b exp=0", alert_n); end
        rd_reg(8'h07);
        total++; if (reg_rdata !== 8'h04) begin bad++; $display("[TB] FAIL basic_status got=%h exp=04", reg_rdata); end
        total++; if (alert_n !== 1'b1) begin bad++; $display("[TB] FAIL basic_alert_clear got=%b exp=1", alert_n); end
        rd_reg(8'h07);
        total++; if (reg_rdata !== 8'h00) begin bad++; $display("[TB] FAIL basic_status_cleared got=%h exp=00", reg_rdata); end
    endtask

    task automatic test_reject();
        wr_reg(8'h00, 8'h45); wr_reg(8'h01, 8'hA3); wr_reg(8'h02, 8'h00); wr_reg(8'h03, 8'h01);
        wr_reg(8'h00, 8'hFF);
        step(1'b0, 1'b0, 8'h00, 8'h00, 2'b01);
        total++; if (cmp0 !== 18'h0A345) begin bad++; $display("[TB] FAIL reject_cmp0 got=%h exp=%h", cmp0, 18'h0A345); end
        rd_reg(8'h07);
        total++; if (reg_rdata !== 8'h44) begin bad++; $display("[TB] FAIL reject_status got=%h exp=44", reg_rdata); end
    endtask

    task automatic test_clamp();
        wr_reg(8'h04, 8'hFF); wr_reg(8'h05, 8'hFF); wr_reg(8'h06, 8'hFF); wr_reg(8'h03, 8'h02);
        step(1'b0, 1'b0, 8'h00, 8'h00, 2'b10);
        total++; if (cmp1 !== 18'h10000) begin bad++; $display("[TB] FAIL clamp_cmp1 got=%h exp=%h", cmp1, 18'h10000); end
        rd_reg(8'h07);
        total++; if (reg_rdata !== 8'h28) begin bad++; $display("[TB] FAIL clamp_status got=%h exp=28", reg_rdata); end
    endtask

    task automatic test_back_to_back();
        wr_reg(8'h00, 8'hBC); wr_reg(8'h01, 8'h0A); wr_reg(8'h02, 8'h00);
        wr_reg(8'h04, 8'h34); wr_reg(8'h05, 8'h12); wr_reg(8'h06, 8'h00);
        wr_reg(8'h03, 8'h03);
        for (int c = 1; c <= 10; c++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00, (c == 5) ? 2'b10 : (c == 9) ? 2'b01 : 2'b00);
            if (c == 5) begin
                total++; if (cmp1 !== 18'h01234) begin bad++; $display("[TB] FAIL dual_cmp1 got=%h exp=%h", cmp1, 18'h01234); end
                total++; if (cmp0 !== 18'h0A345) begin bad++; $display("[TB] FAIL dual_cmp0_hold got=%h exp=%h", cmp0, 18'h0A345); end
            end
            if (c == 9) begin
                total++; if (cmp0 !== 18'h00ABC) begin bad++; $display("[TB] FAIL dual_cmp0 got=%h exp=%h", cmp0, 18'h00ABC); end
            end
        end
        rd_reg(8'h07);
        total++; if (reg_rdata !== 8'h0C) begin bad++; $display("[TB] FAIL dual_status got=%h exp=0C", reg_rdata); end
    endtask

    task automatic test_rw_same_cycle();
        step(1'b1, 1'b1, 8'h00, 8'h5A, 2'b00);
        total++; if (reg_rdata !== 8'hBC) begin bad++; $display("[TB] FAIL rw_pre_write got=%h exp=BC", reg_rdata); end
        rd_reg(8'h00);
        total++; if (reg_rdata !== 8'h5A) begin bad++; $display("[TB] FAIL rw_post_write got=%h exp=5A", reg_rdata); end
        wr_reg(8'h20, 8'h77); rd_reg(8'h20);
        total++; if (reg_rdata !== 8'h00) begin bad++; $display("[TB] FAIL unmapped_read got=%h exp=00", reg_rdata); end
        rd_reg(8'h03);
        total++; if (reg_rdata !== 8'h00) begin bad++; $display("[TB] FAIL ctrl_read got=%h exp=00", reg_rdata); end
    endtask

    task automatic test_reset_mid();
        wr_reg(8'h03, 8'h01);
        idle(1);
        #2 rstn = 1'b0; model_reset();
        #1;
        total++; if (cmp0 !== 18'h0 || cmp1 !== 18'h0) begin bad++; $display("[TB] FAIL rstmid_cmp got=%h/%h exp=0/0", cmp0, cmp1); end
        total++; if (alert_n !== 1'b1 || upd_done !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_flags got=%b/%b exp=1/00", alert_n, upd_done); end
        total++; if (reg_rdata !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_rdata got=%h exp=00", reg_rdata); end
        #2 rstn = 1'b1;
        @(posedge clk_USB); #1;
        step(1'b0, 1'b0, 8'h00, 8'h00, 2'b01);
        total++; if (cmp0 !== 18'h0 || upd_done !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_noload got=%h/%b exp=0/00", cmp0, upd_done); end
        rd_reg(8'h07);
        total++; if (reg_rdata !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_status got=%h exp=00", reg_rdata); end
    endtask

    task automatic test_timeout();
        int cnt;
        int loads;
        wr_reg(8'h01, 8'h01); wr_reg(8'h03, 8'h01);
`ifdef PWM_UPD_TIMEOUT_EN
        cnt = 0;
        while (upd_done[0] !== 1'b1 && cnt < 300) begin
            idle(1); cnt++;
        end
        total++; if (cnt !== TMO_CYC) begin bad++; $display("[TB] FAIL tmo_cycles got=%0d exp=%0d", cnt, TMO_CYC); end
        total++; if (cmp0 !== 18'h00100) begin bad++; $display("[TB] FAIL tmo_cmp0 got=%h exp=%h", cmp0, 18'h00100); end
        total++; if (alert_n !== 1'b0) begin bad++; $display("[TB] FAIL tmo_alert_n got=%b exp=0", alert_n); end
        rd_reg(8'h07);
        total++; if (reg_rdata !== 8'h84) begin bad++; $display("[TB] FAIL tmo_status got=%h exp=84", reg_rdata); end
`else
        loads = 0;
        for (int i = 0; i < 150; i++) begin
            idle(1);
            if (upd_done !== 2'b00) loads++;
        end
        total++; if (loads !== 0) begin bad++; $display("[TB] FAIL notmo_loads got=%0d exp=0", loads); end
        rd_reg(8'h07);
        total++; if (reg_rdata !== 8'h01) begin bad++; $display("[TB] FAIL notmo_status got=%h exp=01", reg_rdata); end
        step(1'b0, 1'b0, 8'h00, 8'h00, 2'b01);
        total++; if (cmp0 !== 18'h00100) begin bad++; $display("[TB] FAIL notmo_cmp0 got=%h exp=%h", cmp0, 18'h00100); end
        rd_reg(8'h07);
`endif
    endtask

    task automatic test_random();
        bit          wr;
        bit          rd;
        logic [7:0]  a;
        logic [7:0]  d;
        logic [1:0]  pe;
        for (int i = 0; i < 400; i++) begin
            wr = ($urandom % 3) == 0;
            rd = ($urandom % 3) == 0;
            a  = (($urandom % 16) == 0) ? 8'h40 : 8'($urandom % 8);
            d  = 8'($urandom);
            pe = {($urandom % 8) == 0, ($urandom % 8) == 0};
            step(wr, rd, a, d, pe);
            total++; if (cmp0 !== m_active[0]) begin bad++; $display("[TB] FAIL rand_cmp0 i=%0d got=%h exp=%h", i, cmp0, m_active[0]); end
            total++; if (cmp1 !== m_active[1]) begin bad++; $display("[TB] FAIL rand_cmp1 i=%0d got=%h exp=%h", i, cmp1, m_active[1]); end
            total++; if (upd_done !== {m_load[1], m_load[0]}) begin bad++; $display("[TB] FAIL rand_upd_done i=%0d got=%b exp=%b", i, upd_done, {m_load[1], m_load[0]}); end
            total++; if (alert_n !== m_alert_n()) begin bad++; $display("[TB] FAIL rand_alert_n i=%0d got=%b exp=%b", i, alert_n, m_alert_n()); end
            total++; if (reg_rdata !== m_rdata) begin bad++; $display("[TB] FAIL rand_rdata i=%0d got=%h exp=%h", i, reg_rdata, m_rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_clamp();
        test_back_to_back();
        test_rw_same_cycle();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
